// File: rtl/ca90_im_fetcher_if.sv
// Purpose: bundles the fetcher's request, sweep, item-memory and output-FIFO signals.
// Latency: none; this is wiring only.
// Backpressure: req_ready_o and hv_ready_i carry the valid/ready handshakes.
// Ports: slave = fetcher side, master = controller/item-memory/consumer side.
interface ca90_im_fetcher_if #(
    parameter int HVDimension = 512,
    parameter int NumTotIm    = 1024,
    parameter int ImSelWidth  = $clog2(NumTotIm),
    parameter int CntWidth    = ImSelWidth + 1
);
    // manual pair request
    logic [ImSelWidth-1:0]  req_sel_a_i;
    logic [ImSelWidth-1:0]  req_sel_b_i;
    logic                   req_valid_i;
    logic                   req_ready_o;
    // automatic sweep control
    logic                   auto_start_i;
    logic [ImSelWidth-1:0]  auto_base_i;
    logic [CntWidth-1:0]    auto_count_i;
    logic                   auto_busy_o;
    // item memory (combinational read)
    logic [ImSelWidth-1:0]  im_sel_a_o;
    logic [ImSelWidth-1:0]  im_sel_b_o;
    logic [HVDimension-1:0] im_a_i;
    logic [HVDimension-1:0] im_b_i;
    // output FIFO head
    logic [HVDimension-1:0] hv_a_o;
    logic [HVDimension-1:0] hv_b_o;
    logic                   hv_last_o;
    logic                   hv_valid_o;
    logic                   hv_ready_i;

    modport slave (
        input  req_sel_a_i, req_sel_b_i, req_valid_i,
        output req_ready_o,
        input  auto_start_i, auto_base_i, auto_count_i,
        output auto_busy_o,
        output im_sel_a_o, im_sel_b_o,
        input  im_a_i, im_b_i,
        output hv_a_o, hv_b_o, hv_last_o, hv_valid_o,
        input  hv_ready_i
    );

    modport master (
        output req_sel_a_i, req_sel_b_i, req_valid_i,
        input  req_ready_o,
        output auto_start_i, auto_base_i, auto_count_i,
        input  auto_busy_o,
        input  im_sel_a_o, im_sel_b_o,
        output im_a_i, im_b_i,
        input  hv_a_o, hv_b_o, hv_last_o, hv_valid_o,
        output hv_ready_i
    );
endinterface

// File: rtl/ca90_im_fetcher.sv
// Purpose: 2-entry register FIFO; head entry is a register so outputs are glitch-free and stable.
// Latency: push at edge t is visible at the head after edge t when the FIFO was empty.
// Backpressure: pushes are dropped when full (caller gates with full_o); pop and push may coincide.
module ca90_im_fetcher_fifo #(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_vld,
    input  logic [Width-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [Width-1:0] head_dat,
    output logic             head_vld,
    output logic             full
);
    logic [Width-1:0] entry0;
    logic [Width-1:0] entry1;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push_vld && (count != 2'd2);
    assign do_pop   = pop_rdy && (count != 2'd0);
    assign head_dat = entry0;
    assign head_vld = (count != 2'd0);
    assign full     = (count == 2'd2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else if (do_push && do_pop) begin
            // both can only happen with exactly one entry: replace the head
            entry0 <= push_dat;
        end else if (do_push) begin
            if (count == 2'd0) begin
                entry0 <= push_dat;
            end else begin
                entry1 <= push_dat;
            end
            count <= count + 2'd1;
        end else if (do_pop) begin
            entry0 <= entry1;
            count  <= count - 2'd1;
        end
    end
endmodule

// Purpose: sequences item-memory reads (manual pairs or a contiguous sweep) into a 2-deep output FIFO.
// Latency: one cycle from accepted request / sweep step to data at the FIFO head.
// Backpressure: FIFO full drops req_ready_o and freezes the sweep; ready never depends on hv_ready_i.
// Ports: clk_i/rst_ni plus the slave modport of ca90_im_fetcher_if (request, sweep, IM select/data, HV output).
module ca90_im_fetcher #(
    parameter int HVDimension = 512,
    parameter int NumTotIm    = 1024,
    parameter int ImSelWidth  = $clog2(NumTotIm),
    parameter int CntWidth    = ImSelWidth + 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    ca90_im_fetcher_if.slave   bus
);
    typedef enum logic {
        IDLE = 1'b0,
        AUTO = 1'b1
    } state_t;

    localparam int EntryWidth = 2 * HVDimension + 1;

    state_t                 state;
    logic [ImSelWidth-1:0]  ptr;
    logic [CntWidth-1:0]    remaining;

    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   last;
    logic [EntryWidth-1:0]  push_dat;
    logic [EntryWidth-1:0]  head_dat;
    logic                   head_vld;

    always_comb begin
        bus.req_ready_o = 1'b0;
        bus.im_sel_a_o  = bus.req_sel_a_i;
        bus.im_sel_b_o  = bus.req_sel_b_i;
        push            = 1'b0;
        last            = 1'b0;
        if (state == IDLE) begin
            bus.req_ready_o = !full;
            push            = bus.req_valid_i && !full;
        end else begin
            // ptr+1 wraps naturally at the index width, giving modulo NumTotIm
            bus.im_sel_a_o = ptr;
            bus.im_sel_b_o = ptr + ImSelWidth'(1);
            push           = !full;
            last           = (remaining == CntWidth'(1));
        end
    end

    assign push_dat = {bus.im_a_i, bus.im_b_i, last};
    assign pop      = head_vld && bus.hv_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // a manual push in this same cycle is unaffected; the sweep begins next cycle
                    if (bus.auto_start_i && (bus.auto_count_i != '0)) begin
                        state     <= AUTO;
                        ptr       <= bus.auto_base_i;
                        remaining <= bus.auto_count_i;
                    end
                end
                AUTO: begin
                    if (!full) begin
                        ptr       <= ptr + ImSelWidth'(1);
                        remaining <= remaining - CntWidth'(1);
                        if (remaining == CntWidth'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ca90_im_fetcher_fifo #(
        .Width (EntryWidth)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_vld (push),
        .push_dat (push_dat),
        .pop_rdy  (pop),
        .head_dat (head_dat),
        .head_vld (head_vld),
        .full     (full)
    );

    assign bus.auto_busy_o = (state == AUTO);
    assign bus.hv_valid_o  = head_vld;
    assign bus.hv_a_o      = head_dat[EntryWidth-1 -: HVDimension];
    assign bus.hv_b_o      = head_dat[HVDimension:1];
    assign bus.hv_last_o   = head_dat[0];
endmodule

// File: tb/tb_ca90_im_fetcher.sv
// Purpose: bench for ca90_im_fetcher with a queue-level reference model and directed scenarios.
// Latency: model predicts the FIFO head one cycle after each accepted request or sweep step.
// Backpressure: exercised by holding hv_ready_i low across a sweep.
module tb_ca90_im_fetcher;
    localparam int HV = 512;
    localparam int NIM = 1024;
    localparam int SW = 10;
    localparam int CW = 11;

    typedef struct packed {
        logic [9:0] a;
        logic [9:0] b;
        logic       last;
    } beat_t;

    logic clk_i;
    logic rst_ni;

    ca90_im_fetcher_if #(.HVDimension(HV), .NumTotIm(NIM), .ImSelWidth(SW), .CntWidth(CW)) bus ();

    ca90_im_fetcher #(.HVDimension(HV), .NumTotIm(NIM), .ImSelWidth(SW), .CntWidth(CW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // Item memory stand-in: every index maps to a distinct pattern whose low 10 bits are the index.
    function automatic logic [HV-1:0] hv_of(input int idx);
        logic [9:0] i;
        i = idx[9:0];
        return {16{6'b101101, 16'hC3A5 ^ {6'b0, i}, i}};
    endfunction

    assign bus.im_a_i = hv_of(int'(bus.im_sel_a_o));
    assign bus.im_b_i = hv_of(int'(bus.im_sel_b_o));

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_hv(input string name, input logic [HV-1:0] act, input int idx);
        logic [HV-1:0] e;
        e = hv_of(idx);
        n_chk++;
        if (act !== e) begin
            $display("FAIL %s: got idx %0d word %h expected idx %0d word %h at %0t",
                     name, act[9:0], act[31:0], idx, e[31:0], $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model (queue of expected beats + sweep record) ----------------
    beat_t mq[$];
    bit    m_busy = 1'b0;
    int    m_nxt  = 0;
    int    m_rem  = 0;
    bit    mt_was_busy;
    bit    mt_full;
    bit    mt_pop;
    bit    mt_push;
    beat_t mt_beat;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mq.delete();
            m_busy = 1'b0;
            m_nxt  = 0;
            m_rem  = 0;
        end else begin
            mt_was_busy = m_busy;
            mt_full     = (mq.size() == 2);
            mt_pop      = (mq.size() != 0) && bus.hv_ready_i;
            mt_push     = 1'b0;
            mt_beat     = '0;
            if (!mt_was_busy) begin
                if (bus.req_valid_i && !mt_full) begin
                    mt_beat = {bus.req_sel_a_i, bus.req_sel_b_i, 1'b0};
                    mt_push = 1'b1;
                end
                if (bus.auto_start_i && bus.auto_count_i != 0) begin
                    m_busy = 1'b1;
                    m_nxt  = int'(bus.auto_base_i);
                    m_rem  = int'(bus.auto_count_i);
                end
            end else if (!mt_full) begin
                mt_beat = {10'(m_nxt), 10'((m_nxt + 1) % NIM), (m_rem == 1)};
                mt_push = 1'b1;
                m_nxt   = (m_nxt + 1) % NIM;
                m_rem   = m_rem - 1;
                if (m_rem == 0) m_busy = 1'b0;
            end
            if (mt_pop) void'(mq.pop_front());
            if (mt_push) mq.push_back(mt_beat);
        end
    end

    // ---------------- per-cycle compare + consumed-beat log ----------------
    beat_t log_q[$];
    int    busy_cnt = 0;

    always @(negedge clk_i) begin
        chk("hv_valid", bus.hv_valid_o, mq.size() != 0);
        if (mq.size() != 0) begin
            chk_hv("hv_a", bus.hv_a_o, int'(mq[0].a));
            chk_hv("hv_b", bus.hv_b_o, int'(mq[0].b));
            chk("hv_last", bus.hv_last_o, mq[0].last);
        end
        chk("req_ready", bus.req_ready_o, !m_busy && mq.size() < 2);
        chk("auto_busy", bus.auto_busy_o, m_busy);
        chk("im_sel_a", bus.im_sel_a_o, m_busy ? m_nxt : int'(bus.req_sel_a_i));
        chk("im_sel_b", bus.im_sel_b_o, m_busy ? (m_nxt + 1) % NIM : int'(bus.req_sel_b_i));
        if (rst_ni && bus.hv_valid_o && bus.hv_ready_i)
            log_q.push_back({bus.hv_a_o[9:0], bus.hv_b_o[9:0], bus.hv_last_o});
        if (bus.auto_busy_o) busy_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic start_sweep(input int base, input int count);
        bus.auto_base_i  = 10'(base);
        bus.auto_count_i = 11'(count);
        bus.auto_start_i = 1'b1;
        step();
        bus.auto_start_i = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (bus.auto_busy_o && n < bound) begin
            step();
            n++;
        end
        chk("sweep_done_in_budget", bus.auto_busy_o, 1'b0);
    endtask

    task automatic chk_beat(input int i, input int a, input int b, input bit last);
        beat_t e;
        e = {10'(a), 10'(b), last};
        if (i < log_q.size()) chk($sformatf("beat%0d", i), log_q[i], e);
        else chk($sformatf("beat%0d_missing", i), 64'(log_q.size()), 64'(i + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_ni           = 1'b0;
        bus.req_sel_a_i  = 10'd33;
        bus.req_sel_b_i  = 10'd44;
        bus.req_valid_i  = 1'b0;
        bus.auto_start_i = 1'b0;
        bus.auto_base_i  = '0;
        bus.auto_count_i = '0;
        bus.hv_ready_i   = 1'b1;
        repeat (3) step();

        // reset values
        chk("rst_req_ready", bus.req_ready_o, 1'b1);
        chk("rst_busy", bus.auto_busy_o, 1'b0);
        chk("rst_valid", bus.hv_valid_o, 1'b0);
        chk("rst_last", bus.hv_last_o, 1'b0);
        chk("rst_hv_a", bus.hv_a_o[63:0], 64'd0);
        chk("rst_hv_b", bus.hv_b_o[63:0], 64'd0);
        chk("rst_im_sel_a", bus.im_sel_a_o, 10'd33);
        rst_ni = 1'b1;
        step();

        // manual pair
        log_q.delete();
        bus.req_sel_a_i = 10'd5;
        bus.req_sel_b_i = 10'd900;
        bus.req_valid_i = 1'b1;
        step();
        bus.req_valid_i = 1'b0;
        chk("man_valid", bus.hv_valid_o, 1'b1);
        chk("man_a", bus.hv_a_o[9:0], 10'd5);
        chk("man_b", bus.hv_b_o[9:0], 10'd900);
        chk("man_last", bus.hv_last_o, 1'b0);
        step();
        chk("man_valid_one_cycle", bus.hv_valid_o, 1'b0);
        chk("man_log_len", log_q.size(), 1);

        // sweep base 100 count 4
        log_q.delete();
        busy_cnt = 0;
        start_sweep(100, 4);
        wait_idle(20);
        repeat (2) step();
        chk("sweep_busy_cycles", busy_cnt, 4);
        chk("sweep_log_len", log_q.size(), 4);
        chk_beat(0, 100, 101, 0);
        chk_beat(1, 101, 102, 0);
        chk_beat(2, 102, 103, 0);
        chk_beat(3, 103, 104, 1);

        // wrap
        log_q.delete();
        start_sweep(1022, 3);
        wait_idle(20);
        repeat (2) step();
        chk("wrap_log_len", log_q.size(), 3);
        chk_beat(0, 1022, 1023, 0);
        chk_beat(1, 1023, 0, 0);
        chk_beat(2, 0, 1, 1);

        // backpressure
        log_q.delete();
        bus.hv_ready_i = 1'b0;
        start_sweep(200, 5);
        repeat (5) step();
        chk("bp_ptr_stall_a", bus.im_sel_a_o, 10'd202);
        chk("bp_ptr_stall_b", bus.im_sel_b_o, 10'd203);
        chk("bp_busy", bus.auto_busy_o, 1'b1);
        chk("bp_req_ready", bus.req_ready_o, 1'b0);
        chk("bp_head", bus.hv_a_o[9:0], 10'd200);
        bus.hv_ready_i = 1'b1;
        wait_idle(20);
        repeat (3) step();
        chk("bp_log_len", log_q.size(), 5);
        for (int i = 0; i < 5; i++) chk_beat(i, 200 + i, 201 + i, i == 4);

        // count 0 start is ignored
        start_sweep(77, 0);
        chk("zero_busy", bus.auto_busy_o, 1'b0);
        chk("zero_req_ready", bus.req_ready_o, 1'b1);

        // start and manual request while sweeping
        log_q.delete();
        start_sweep(300, 3);
        bus.auto_base_i  = 10'd500;
        bus.auto_count_i = 11'd7;
        bus.auto_start_i = 1'b1;
        bus.req_sel_a_i  = 10'd7;
        bus.req_sel_b_i  = 10'd8;
        bus.req_valid_i  = 1'b1;
        step();
        bus.auto_start_i = 1'b0;
        chk("auto_req_ready_low", bus.req_ready_o, 1'b0);
        for (int n = 0; n < 20 && bus.req_valid_i; n++) begin
            if (bus.req_ready_o) begin
                step();
                bus.req_valid_i = 1'b0;
            end else begin
                step();
            end
        end
        chk("late_req_accepted", bus.req_valid_i, 1'b0);
        repeat (3) step();
        chk("restart_busy", bus.auto_busy_o, 1'b0);
        chk("restart_log_len", log_q.size(), 4);
        chk_beat(0, 300, 301, 0);
        chk_beat(1, 301, 302, 0);
        chk_beat(2, 302, 303, 1);
        chk_beat(3, 7, 8, 0);

        // reset mid-sweep after 3 pushes
        log_q.delete();
        start_sweep(10, 8);
        repeat (3) step();
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", bus.hv_valid_o, 1'b0);
        chk("mid_rst_busy", bus.auto_busy_o, 1'b0);
        chk("mid_rst_req_ready", bus.req_ready_o, 1'b1);
        chk("mid_rst_last", bus.hv_last_o, 1'b0);
        repeat (2) step();
        rst_ni = 1'b1;
        repeat (10) step();
        chk("mid_rst_no_more_beats", log_q.size(), 2);
        chk_beat(0, 10, 11, 0);
        chk_beat(1, 11, 12, 0);
        chk("mid_rst_busy_after", bus.auto_busy_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
